// File: rtl/toggle_pulse_gen_pkg.sv
// Shared types and constants for the toggle-enable pulse generator.
// The FSM encoding and the magic codes on the divide and burst inputs live here.
package toggle_pulse_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A divide ratio of 0 is replaced by this value.
    localparam int ZERO_DIV_SUB = 1;

    // A burst length equal to this code selects continuous mode.
    localparam int BURST_CONT = 0;

endpackage

// File: rtl/tick_prescaler.sv
// Down-counting prescaler with auto-reload: ticks while enabled on count zero.
// A load presets the count to reload-1, so the first tick comes reload enabled cycles later.
module tick_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] reload,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload_m1;

    assign reload_m1 = reload - DIV_W'(1);
    assign tick      = en && (cnt == '0);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples its inputs as they were before the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload_m1;
        end else if (en) begin
            cnt <= (cnt == '0) ? reload_m1 : cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/toggle_pulse_gen.sv
// Programmable toggle-enable generator feeding a T flip-flop's t input:
// single-cycle pulses every div cycles, as a finite burst or continuously.
module toggle_pulse_gen
    import toggle_pulse_gen_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div_i,
    input  logic [CNT_W-1:0] burst_i,
    output logic             t_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulse_cnt
);

    state_t           state, state_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [CNT_W-1:0] burst_q, burst_n;
    logic [CNT_W-1:0] cnt_n;
    logic             t_n, busy_n, done_n;

    logic [DIV_W-1:0] eff_div;
    logic [DIV_W-1:0] reload;
    logic             load, en, tick;
    logic             continuous, burst_end;

    assign eff_div    = (div_i == '0) ? DIV_W'(ZERO_DIV_SUB) : div_i;
    // The prescaler reloads from the live input on start, from the latched ratio afterwards.
    assign reload     = load ? eff_div : div_q;
    assign continuous = (burst_q == CNT_W'(BURST_CONT));
    assign burst_end  = !continuous && (pulse_cnt == burst_q);

    tick_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk    (clk),
        .rstn   (rstn),
        .load   (load),
        .en     (en),
        .reload (reload),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            div_q     <= '0;
            burst_q   <= '0;
            pulse_cnt <= '0;
            t_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            div_q     <= div_n;
            burst_q   <= burst_n;
            pulse_cnt <= cnt_n;
            t_out     <= t_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        div_n   = div_q;
        burst_n = burst_q;
        cnt_n   = pulse_cnt;
        t_n     = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        load    = 1'b0;
        en      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_n = ST_RUN;
                    div_n   = eff_div;
                    burst_n = burst_i;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    load    = 1'b1;
                end
            end

            ST_RUN: begin
                // Stop beats both the burst end and a coinciding prescaler tick.
                if (stop) begin
                    state_n = ST_IDLE;
                end else if (burst_end) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else begin
                    busy_n = 1'b1;
                    en     = 1'b1;
                    if (tick) begin
                        t_n   = 1'b1;
                        cnt_n = pulse_cnt + CNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                state_n = ST_IDLE;
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/toggle_pulse_gen.md
Name: toggle_pulse_gen

Overview:
Programmable toggle-enable generator that sits directly upstream of the T flip-flop stage. It drives that stage's t input.
- Emits single-cycle t pulses spaced a programmable number of clock cycles apart.
- Runs either a finite burst of N pulses or continuously.
- Provides busy/done status and a pulse count for the controlling logic.

Parameters:
DIV_W, 8, width of the divide-ratio input and internal prescaler
CNT_W, 8, width of the burst-length input and pulse counter

Ports:
clk        in   1      system clock, all state updates on rising edge
rstn       in   1      asynchronous active-low reset
start      in   1      request to begin a sequence (sampled only in IDLE)
stop       in   1      abort request (sampled in IDLE and RUN)
div_i      in   DIV_W  pulse period in clk cycles; 0 is treated as 1
burst_i    in   CNT_W  number of pulses; 0 means continuous
t_out      out  1      registered one-cycle toggle-enable pulse, to the T flip-flop t input
busy       out  1      high while in RUN
done       out  1      one-cycle pulse after the final pulse of a finite burst
pulse_cnt  out  CNT_W  pulses issued since last start

Behaviour:
- Reset (rstn=0, asynchronous, any state): state=IDLE; t_out=0, busy=0, done=0, pulse_cnt=0; prescaler and latched config cleared.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 and stop=0 at an edge: latch div_i (0 becomes 1) and burst_i; load prescaler with div-1; clear pulse_cnt; go to RUN (busy=1 after that edge).
  - stop=1 (with or without start): stay in IDLE.
- RUN:
  - Prescaler decrements every cycle.
  - When the prescaler is 0 at an edge: t_out=1 for the following cycle; prescaler reloads div-1; pulse_cnt increments.
  - Timing: start sampled at edge E0 gives pulses after edges E(div), E(2·div), ...
  - div=1 gives t_out high every cycle.
- Burst end: with burst≠0, the edge that issues pulse number burst keeps the state in RUN. The next edge goes to DONE with done=1, busy=0, t_out=0.
- DONE lasts exactly one cycle, then IDLE with done=0. pulse_cnt holds its final value until the next start.
- Continuous mode (burst=0): never enters DONE; pulse_cnt wraps from 2^CNT_W-1 to 0.
- stop in RUN:
  - Next state is IDLE; busy=0; done stays 0; pulse_cnt holds.
  - If stop coincides with a prescaler-zero edge, stop wins and no pulse is issued.
- start while busy or in DONE: ignored. div_i and burst_i changes during RUN: ignored (latched values are used).
- Reset asserted mid-burst: immediate return to the reset values; no done pulse.
- Downstream contract: the T flip-flop samples t_out on the edge following the pulse cycle, so q toggles once per pulse.

Decomposition:
- Package toggle_pulse_gen_pkg:
  - state enum (IDLE, RUN, DONE)
  - localparams for zero-divide substitution (1) and the continuous-mode burst code (0)
- Sub-module tick_prescaler:
  - load / enable inputs and a DIV_W reload value
  - tick output on count zero, with auto-reload
  - instantiated once; the FSM and pulse counter stay in the top.

Test Plan:
1. Reset mid-burst: div=3, burst=5, rstn low after 2 pulses → t_out, busy, done, pulse_cnt all 0 immediately; no further pulses after release.
2. Finite burst: div=3, burst=2, start at E0 → t_out high after E3 and E6 only; done high E7–E8; busy high E0–E7; pulse_cnt=2 held; downstream q toggles twice.
3. div=0 and div=1: burst=4 → four back-to-back t_out cycles after E1..E4; done after E5; pulse_cnt=4.
4. Continuous wrap: CNT_W=3, div=1, burst=0 → t_out stays high; pulse_cnt counts 1..7,0,1; done never asserts.
5. Stop collision: div=4, burst=0, stop asserted on the third prescaler-zero edge → only 2 pulses; state IDLE; busy=0; done=0; pulse_cnt=2.
6. Ignored inputs: start+stop together in IDLE → remains IDLE. Second start and div_i change mid-RUN → period and burst unchanged, pulse_cnt not cleared.
